// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one pipelined 8-operand adder among NUM_REQ requesters. A round-robin
// arbiter issues at most one operand bundle per cycle into the adder. A tag pipe
// matched to the adder latency steers each sum back to the requester that
// issued it. Disagreement between the tag pipe and the adder's valid output
// raises a sticky error.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   enable         low blocks new grants; in-flight work still drains
//   req_valid      per-requester bundle valid
//   req_ops        NUM_REQ bundles of eight DATA_W operands (A = LSB slice)
//   req_ready      one-hot combinational grant
//   add_ops        registered operands A..H to the adder
//   add_valid      registered adder valid_input
//   add_result     adder sum (DATA_W+3 bits)
//   add_valid_out  adder valid_output
//   rsp_valid      registered one-hot result strobe
//   rsp_result     registered sum
//   inflight       bundles issued but not yet returned
//   idle           nothing in flight and no response pending
//   err            sticky valid-mismatch flag
//   issue_cnt      wrapping count of issued bundles
module adder_share_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int ADDER_LAT = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*8*DATA_W-1:0]      req_ops,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [8*DATA_W-1:0]              add_ops,
    output logic                             add_valid,
    input  logic [DATA_W+2:0]                add_result,
    input  logic                             add_valid_out,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_W+2:0]                rsp_result,
    output logic [$clog2(ADDER_LAT+3)-1:0]   inflight,
    output logic                             idle,
    output logic                             err,
    output logic [15:0]                      issue_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ADDER_LAT + 3);
    localparam int BUN_W = 8 * DATA_W;
    localparam int RES_W = DATA_W + 3;
    // Slot 0 is loaded together with add_valid; the last slot lines up with
    // add_valid_out for the same bundle (one cycle into the adder plus
    // ADDER_LAT cycles inside it).
    localparam int DEPTH = ADDER_LAT + 2;

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_gnt_idx;
    logic [IDX_W-1:0] w_sel;
    logic             w_gnt_any;
    int               w_scan;

    // Round-robin grant: scan downward so the requester closest at or after
    // r_ptr is the last match and therefore the winner.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_scan    = 0;
        w_sel     = '0;
        req_ready = '0;
        if (rst_n && enable) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_scan = (int'(r_ptr) + k) % NUM_REQ;
                w_sel  = IDX_W'(w_scan);
                if (req_valid[w_sel]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_idx = w_sel;
                end
            end
            req_ready[w_gnt_idx] = w_gnt_any;
        end
    end

    // ---- issue stage: operands and valid registered toward the adder ----
    logic             r_add_valid;
    logic [BUN_W-1:0] r_add_ops;
    logic [15:0]      r_issue_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_add_valid <= 1'b0;
            r_add_ops   <= '0;
            r_ptr       <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_add_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_add_ops   <= req_ops[w_gnt_idx*BUN_W +: BUN_W];
                r_issue_cnt <= r_issue_cnt + 16'd1;
                r_ptr       <= (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + IDX_W'(1);
            end
        end
    end

    // ---- tag pipe: requester index travels alongside the adder pipeline ----
    logic [DEPTH-1:0] r_tag_vld_p;
    logic [IDX_W-1:0] r_tag_idx_p [DEPTH];
    logic             w_exit_vld;
    logic [IDX_W-1:0] w_exit_idx;
    logic             w_retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag_vld_p <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                r_tag_idx_p[s] <= '0;
            end
        end else begin
            r_tag_vld_p    <= {r_tag_vld_p[DEPTH-2:0], w_gnt_any};
            r_tag_idx_p[0] <= w_gnt_idx;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag_idx_p[s] <= r_tag_idx_p[s-1];
            end
        end
    end

    assign w_exit_vld = r_tag_vld_p[DEPTH-1];
    assign w_exit_idx = r_tag_idx_p[DEPTH-1];
    // A bundle stops counting as in flight once its tag reaches the exit slot,
    // where it meets the adder output and becomes a pending response.
    assign w_retire   = r_tag_vld_p[DEPTH-2];

    logic [CNT_W-1:0] r_inflight;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else if (w_gnt_any && !w_retire) begin
            r_inflight <= r_inflight + CNT_W'(1);
        end else if (!w_gnt_any && w_retire) begin
            r_inflight <= r_inflight - CNT_W'(1);
        end
    end

    // ---- response stage: route sum to the tagged requester ----
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [RES_W-1:0]   r_rsp_result;
    logic               r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid  <= '0;
            r_rsp_result <= '0;
            r_err        <= 1'b0;
        end else begin
            r_rsp_valid <= '0;
            if (add_valid_out && w_exit_vld) begin
                r_rsp_valid[w_exit_idx] <= 1'b1;
                r_rsp_result            <= add_result;
            end
            // Result without a tag, or tag without a result: neither responds.
            if (add_valid_out != w_exit_vld) begin
                r_err <= 1'b1;
            end
        end
    end

    assign add_valid  = r_add_valid;
    assign add_ops    = r_add_ops;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_rsp_result;
    assign inflight   = r_inflight;
    assign err        = r_err;
    assign issue_cnt  = r_issue_cnt;
    assign idle       = (r_inflight == '0) && !w_exit_vld && !(|r_rsp_valid);

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural pipelined adder.
module tb_adder_share_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int ADDER_LAT = 3;

    logic                           clk;
    logic                           rst_n;
    logic                           enable;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*8*DATA_W-1:0]    req_ops;
    logic [NUM_REQ-1:0]             req_ready;
    logic [8*DATA_W-1:0]            add_ops;
    logic                           add_valid;
    logic [DATA_W+2:0]              add_result;
    logic                           add_valid_out;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W+2:0]              rsp_result;
    logic [$clog2(ADDER_LAT+3)-1:0] inflight;
    logic                           idle;
    logic                           err;
    logic [15:0]                    issue_cnt;

    adder_share_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .ADDER_LAT(ADDER_LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_ops      (req_ops),
        .req_ready    (req_ready),
        .add_ops      (add_ops),
        .add_valid    (add_valid),
        .add_result   (add_result),
        .add_valid_out(add_valid_out),
        .rsp_valid    (rsp_valid),
        .rsp_result   (rsp_result),
        .inflight     (inflight),
        .idle         (idle),
        .err          (err),
        .issue_cnt    (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: samples valid_input at an edge, raises valid_output
    // ADDER_LAT edges later; shares rst_n with the arbiter.
    logic [ADDER_LAT:0] m_vld;
    logic [DATA_W+2:0]  m_sum [ADDER_LAT+1];
    logic               force_spur;

    function automatic logic [DATA_W+2:0] sum8(input logic [8*DATA_W-1:0] b);
        logic [DATA_W+2:0] acc;
        acc = '0;
        for (int j = 0; j < 8; j++) acc = acc + (DATA_W+3)'(b[j*DATA_W +: DATA_W]);
        return acc;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) m_vld <= '0;
        else        m_vld <= {m_vld[ADDER_LAT-1:0], add_valid};
        m_sum[0] <= sum8(add_ops);
        for (int s = 1; s <= ADDER_LAT; s++) m_sum[s] <= m_sum[s-1];
    end

    assign add_valid_out = m_vld[ADDER_LAT] | force_spur;
    assign add_result    = m_sum[ADDER_LAT];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input int r, input int first, input int stride);
        for (int j = 0; j < 8; j++)
            req_ops[(r*8+j)*DATA_W +: DATA_W] = DATA_W'(first + stride*j);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    logic [NUM_REQ-1:0] rsp_seen;
    logic [10:0]        exp_res [4];

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        req_valid  = '1;
        req_ops    = '0;
        force_spur = 1'b0;

        // ---- reset state ----
        #1;
        check_eq("ready_in_reset", req_ready, 0);
        step();
        step();
        check_eq("ready_in_reset2", req_ready, 0);
        check_eq("rst_add_valid", add_valid, 0);
        check_eq("rst_add_ops", add_ops, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_result", rsp_result, 0);
        check_eq("rst_inflight", inflight, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_err", err, 0);
        check_eq("rst_issue_cnt", issue_cnt, 0);
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // ---- single requester 0, ops 1..8 ----
        set_bundle(0, 1, 1);
        req_valid = 4'b0001;
        #1;
        check_eq("t1_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        check_eq("t1_add_valid", add_valid, 1);
        check_eq("t1_add_ops", add_ops, 64'h0807060504030201);
        check_eq("t1_issue_cnt", issue_cnt, 1);
        check_eq("t1_inflight", inflight, 1);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_eq("t1_rsp_early", rsp_valid, 0);
        end
        step();
        check_eq("t1_rsp_valid", rsp_valid, 4'b0001);
        check_eq("t1_rsp_result", rsp_result, 36);
        step();
        check_eq("t1_rsp_pulse", rsp_valid, 0);
        check_eq("t1_idle", idle, 1);

        // ---- all four at once: 36, 360, 2040, 0 ----
        do_reset();
        set_bundle(0, 1, 1);
        set_bundle(1, 10, 10);
        set_bundle(2, 255, 0);
        set_bundle(3, 0, 0);
        exp_res[0] = 11'd36;
        exp_res[1] = 11'd360;
        exp_res[2] = 11'd2040;
        exp_res[3] = 11'd0;
        req_valid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            #1;
            check_eq("t2_grant", req_ready, 64'(1) << g);
            step();
            req_valid[g] = 1'b0;
        end
        check_eq("t2_inflight_peak", inflight, 4);
        for (int k = 4; k <= 8; k++) begin
            step();
            if (k == 4) check_eq("t2_inflight_drop", inflight, 3);
            if (k < 5) begin
                check_eq("t2_rsp_early", rsp_valid, 0);
            end else begin
                check_eq("t2_rsp_valid", rsp_valid, 64'(1) << (k-5));
                check_eq("t2_rsp_result", rsp_result, exp_res[k-5]);
            end
        end

        // ---- requesters 1 and 3 continuous: alternate with no bubbles ----
        req_valid = 4'b1010;
        for (int g = 0; g < 10; g++) begin
            #1;
            check_eq("t3_grant", req_ready, (g % 2 == 0) ? 4'b0010 : 4'b1000);
            step();
            check_eq("t3_add_valid", add_valid, 1);
            if (g >= 3) check_eq("t3_inflight_sat", inflight, 4);
            if (g >= 5) begin
                check_eq("t3_rsp_valid", rsp_valid, ((g-5) % 2 == 0) ? 4'b0010 : 4'b1000);
                check_eq("t3_rsp_result", rsp_result, ((g-5) % 2 == 0) ? 360 : 0);
            end
        end
        req_valid = '0;
        for (int c = 0; c < 6; c++) step();
        check_eq("t3_idle", idle, 1);
        check_eq("t3_issue_cnt", issue_cnt, 14);

        // ---- enable low with two bundles in flight ----
        req_valid = 4'b0001;
        #1;
        check_eq("t4_grant0a", req_ready, 4'b0001);
        step();
        #1;
        check_eq("t4_grant0b", req_ready, 4'b0001);
        step();
        enable    = 1'b0;
        req_valid = 4'b0100;
        check_eq("t4_inflight", inflight, 2);
        for (int k = 2; k <= 7; k++) begin
            #1;
            check_eq("t4_ready_blocked", req_ready, 0);
            step();
            check_eq("t4_rsp_valid", rsp_valid, (k == 5 || k == 6) ? 4'b0001 : 4'b0000);
            if (k == 5 || k == 6) check_eq("t4_rsp_result", rsp_result, 36);
        end
        check_eq("t4_idle", idle, 1);
        enable = 1'b1;
        #1;
        check_eq("t4_regrant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        check_eq("t4_add_valid", add_valid, 1);
        for (int c = 0; c < 7; c++) step();
        check_eq("t4_idle_end", idle, 1);
        check_eq("t4_err_clean", err, 0);

        // ---- spurious adder valid ----
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        check_eq("t5_err_set", err, 1);
        rsp_seen = '0;
        for (int c = 0; c < 4; c++) begin
            rsp_seen |= rsp_valid;
            step();
        end
        check_eq("t5_no_rsp", rsp_seen, 0);
        check_eq("t5_err_sticky", err, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t5_err_cleared", err, 0);

        // ---- reset with three bundles in flight ----
        step();
        req_valid = 4'b0111;
        for (int g = 0; g < 3; g++) begin
            #1;
            check_eq("t6_grant", req_ready, 64'(1) << g);
            step();
            req_valid[g] = 1'b0;
        end
        check_eq("t6_inflight_pre", inflight, 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_eq("t6_inflight", inflight, 0);
        check_eq("t6_issue_cnt", issue_cnt, 0);
        check_eq("t6_add_valid", add_valid, 0);
        rsp_seen = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            rsp_seen |= rsp_valid;
        end
        check_eq("t6_no_rsp", rsp_seen, 0);
        check_eq("t6_err", err, 0);
        check_eq("t6_idle", idle, 1);
        req_valid = 4'b1111;
        #1;
        check_eq("t6_ptr_restart", req_ready, 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
